hls_snn_deadlock_report_ctrl: RTL and testbench



---
 rtl/hls_snn_deadlock_report_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hls_snn_deadlock_report_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_snn_deadlock_report_ctrl.sv
// hls_snn_deadlock_report_ctrl
//
// Purpose:
//   This block consumes the per-instance deadlock monitor `block` outputs of
//   the HLS SNN design. A deadlock is declared only when some monitor has been
//   blocking for THRESH consecutive cycles. Short, transient blocking does not
//   trigger it.
//   During the episode the block accumulates which monitors were involved. It
//   timestamps the start of the episode with a free-running cycle counter.
//   It delivers exactly one report per deadlock over a valid/ready handshake.
//   The sticky `deadlock` flag stays set until `clear` is sampled after the
//   report has been delivered.
//
// Parameters:
//   NUM_MON  number of monitor block inputs (>= 1)
//   THRESH   consecutive blocked cycles needed to declare deadlock (>= 1)
//   CNT_W    width of the cycle counter and of the timestamp
//
// Ports:
//   clock         in   sole clock, all state updates on the rising edge
//   reset         in   synchronous, active-high reset
//   block_sigs    in   per-monitor block indications (bit i = monitor i)
//   clear         in   single-cycle re-arm request after a delivered report
//   report_ready  in   consumer accepts the report
//   report_valid  out  report available
//   report_mask   out  OR of all block_sigs seen during the episode
//   report_cycle  out  cycle counter value at episode start
//   deadlock      out  sticky deadlock flag
module hls_snn_deadlock_report_ctrl #(
  parameter int NUM_MON = 4,
  parameter int THRESH  = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] block_sigs,
  input  logic               clear,
  input  logic               report_ready,
  output logic               report_valid,
  output logic [NUM_MON-1:0] report_mask,
  output logic [CNT_W-1:0]   report_cycle,
  output logic               deadlock
);

  // The persistence counter only has to reach THRESH. The FSM leaves COUNT
  // on that value, so the counter can never wrap.
  localparam int PW = $clog2(THRESH + 1);
  localparam logic [PW-1:0] THRESH_P = PW'(THRESH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cyc_cnt_reg;
  logic [PW-1:0]      persist_reg, persist_next;
  logic [NUM_MON-1:0] mask_reg, mask_next;
  logic [CNT_W-1:0]   start_reg, start_next;
  logic [NUM_MON-1:0] report_mask_reg, report_mask_next;
  logic [CNT_W-1:0]   report_cycle_reg, report_cycle_next;

  logic               any_block;
  logic [NUM_MON-1:0] mask_acc;
  logic [PW-1:0]      persist_inc;

  // Only an all-zero vector breaks an episode. Which monitors are blocking
  // may change from cycle to cycle without ending it.
  assign any_block   = |block_sigs;
  assign persist_inc = persist_reg + PW'(1);

  // This is the involvement mask after this cycle's block indications are
  // merged into it.
  for (genvar gi = 0; gi < NUM_MON; gi++) begin : g_mask_acc
    assign mask_acc[gi] = mask_reg[gi] | block_sigs[gi];
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic.
  // The report registers are loaded only when the FSM enters REPORT. They
  // therefore stay stable for the whole handshake, however long it takes.
  // They remain visible until the next episode overwrites them.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    persist_next      = persist_reg;
    mask_next         = mask_reg;
    start_next        = start_reg;
    report_mask_next  = report_mask_reg;
    report_cycle_next = report_cycle_reg;

    case (state_reg)
      IDLE: begin
        if (clear) begin
          // A clear takes priority over any blocking seen in the same cycle.
          persist_next = '0;
          mask_next    = '0;
        end else if (any_block) begin
          persist_next = PW'(1);
          mask_next    = block_sigs;
          start_next   = cyc_cnt_reg;
          if (THRESH == 1) begin
            // The first blocked edge already satisfies the threshold.
            state_next        = REPORT;
            report_mask_next  = block_sigs;
            report_cycle_next = cyc_cnt_reg;
          end else begin
            state_next = COUNT;
          end
        end
      end

      COUNT: begin
        if (clear || !any_block) begin
          state_next   = IDLE;
          persist_next = '0;
          mask_next    = '0;
        end else begin
          persist_next = persist_inc;
          mask_next    = mask_acc;
          if (persist_inc == THRESH_P) begin
            state_next        = REPORT;
            report_mask_next  = mask_acc;
            report_cycle_next = start_reg;
          end
        end
      end

      REPORT: begin
        // block_sigs and clear are ignored here, so a report is never dropped.
        if (report_ready) begin
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (clear) begin
          state_next   = IDLE;
          persist_next = '0;
          mask_next    = '0;
        end
      end

      default: begin
        state_next   = IDLE;
        persist_next = '0;
        mask_next    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      cyc_cnt_reg      <= '0;
      persist_reg      <= '0;
      mask_reg         <= '0;
      start_reg        <= '0;
      report_mask_reg  <= '0;
      report_cycle_reg <= '0;
    end else begin
      state_reg        <= state_next;
      cyc_cnt_reg      <= cyc_cnt_reg + CNT_W'(1);
      persist_reg      <= persist_next;
      mask_reg         <= mask_next;
      start_reg        <= start_next;
      report_mask_reg  <= report_mask_next;
      report_cycle_reg <= report_cycle_next;
    end
  end

  // The outputs are decoded purely from registered state. This keeps any
  // combinational path from report_ready to report_valid out of the design.
  assign report_valid = (state_reg == REPORT);
  assign deadlock     = (state_reg == REPORT) || (state_reg == HOLD);
  assign report_mask  = report_mask_reg;
  assign report_cycle = report_cycle_reg;

endmodule

// File: tb/tb_hls_snn_deadlock_report_ctrl.sv
// tb_hls_snn_deadlock_report_ctrl
//
// Purpose:
//   This is a directed bench for hls_snn_deadlock_report_ctrl. It uses three
//   instances:
//     u_dut0  THRESH=16, CNT_W=32  threshold, mask, backpressure, clear, reset
//     u_dut1  THRESH=4,  CNT_W=4   timestamp wrap
//     u_dut2  THRESH=1,  CNT_W=8   single-edge episode
//   Inputs are driven, and outputs sampled, 1 time unit after each rising
//   edge. The expected cycle counter value is tracked by edge counting.
module tb_hls_snn_deadlock_report_ctrl;

  logic clock;
  logic reset;

  logic [3:0]  b0, m0;
  logic        clr0, rdy0, v0, d0;
  logic [31:0] c0;

  logic [3:0]  b1, m1;
  logic        clr1, rdy1, v1, d1;
  logic [3:0]  c1;

  logic [3:0]  b2, m2;
  logic        clr2, rdy2, v2, d2;
  logic [7:0]  c2;

  int          checks;
  int          errors;
  logic [63:0] exp_cyc;
  logic [63:0] start;

  hls_snn_deadlock_report_ctrl #(.NUM_MON(4), .THRESH(16), .CNT_W(32)) u_dut0 (
    .clock(clock), .reset(reset), .block_sigs(b0), .clear(clr0),
    .report_ready(rdy0), .report_valid(v0), .report_mask(m0),
    .report_cycle(c0), .deadlock(d0)
  );

  hls_snn_deadlock_report_ctrl #(.NUM_MON(4), .THRESH(4), .CNT_W(4)) u_dut1 (
    .clock(clock), .reset(reset), .block_sigs(b1), .clear(clr1),
    .report_ready(rdy1), .report_valid(v1), .report_mask(m1),
    .report_cycle(c1), .deadlock(d1)
  );

  hls_snn_deadlock_report_ctrl #(.NUM_MON(4), .THRESH(1), .CNT_W(8)) u_dut2 (
    .clock(clock), .reset(reset), .block_sigs(b2), .clear(clr2),
    .report_ready(rdy2), .report_valid(v2), .report_mask(m2),
    .report_cycle(c2), .deadlock(d2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value and count it.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  // The counter model mirrors the edge that was just taken: a reset edge
  // loads 0, and any other edge adds 1.
  task automatic tick();
    logic rst_at_edge;
    rst_at_edge = reset;
    @(posedge clock);
    #1;
    if (rst_at_edge) exp_cyc = 64'd0;
    else             exp_cyc = exp_cyc + 64'd1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    checks  = 0;
    errors  = 0;
    exp_cyc = 64'd0;
    reset = 1'b1;
    b0 = 4'd0; clr0 = 1'b0; rdy0 = 1'b0;
    b1 = 4'd0; clr1 = 1'b0; rdy1 = 1'b0;
    b2 = 4'd0; clr2 = 1'b0; rdy2 = 1'b0;

    // ---------------- reset state ----------------
    @(posedge clock); #1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", {63'd0, v0}, 64'd0);
    check("rst_deadlock", {63'd0, d0}, 64'd0);
    check("rst_mask", {60'd0, m0}, 64'd0);
    check("rst_cycle", {32'd0, c0}, 64'd0);
    check("rst_valid_t1", {63'd0, v1}, 64'd0);
    check("rst_deadlock_t1", {63'd0, d2}, 64'd0);

    // ---------------- 15 edges: below threshold ----------------
    b0 = 4'b0100;
    repeat (15) tick();
    check("thr15_valid", {63'd0, v0}, 64'd0);
    b0 = 4'd0;
    tick();
    check("thr15_valid_after", {63'd0, v0}, 64'd0);
    check("thr15_deadlock", {63'd0, d0}, 64'd0);
    tick();

    // ---------------- 16 edges: at threshold ----------------
    start = exp_cyc;
    b0 = 4'b0100;
    repeat (15) tick();
    check("thr16_pre_valid", {63'd0, v0}, 64'd0);
    tick();
    b0 = 4'd0;
    check("thr16_valid", {63'd0, v0}, 64'd1);
    check("thr16_deadlock", {63'd0, d0}, 64'd1);
    check("thr16_mask", {60'd0, m0}, 64'd4);
    check("thr16_cycle", {32'd0, c0}, {32'd0, start[31:0]});

    // ---------------- backpressure, with clear ignored in REPORT ----------------
    for (int i = 0; i < 5; i++) begin
      clr0 = (i == 2);
      tick();
      check("bp_valid", {63'd0, v0}, 64'd1);
      check("bp_mask", {60'd0, m0}, 64'd4);
      check("bp_cycle", {32'd0, c0}, {32'd0, start[31:0]});
    end
    clr0 = 1'b0;
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    $display("report0 mask=%b cycle=%0d", m0, c0);
    check("xfer_valid_drop", {63'd0, v0}, 64'd0);
    check("xfer_deadlock_sticky", {63'd0, d0}, 64'd1);
    tick();
    check("xfer_single", {63'd0, v0}, 64'd0);

    // ---------------- HOLD ignores blocking ----------------
    b0 = 4'b1111;
    repeat (20) tick();
    b0 = 4'd0;
    check("hold_valid", {63'd0, v0}, 64'd0);
    check("hold_deadlock", {63'd0, d0}, 64'd1);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    check("clear_deadlock", {63'd0, d0}, 64'd0);
    check("clear_valid", {63'd0, v0}, 64'd0);

    // ---------------- mask accumulation: bit0 on edges 0-9, bit2 on edges 5-20 ----------------
    start = exp_cyc;
    for (int k = 0; k <= 20; k++) begin
      b0 = {1'b0, (k >= 5 && k <= 20), 1'b0, (k <= 9)};
      tick();
      if (k == 14) check("acc_pre_valid", {63'd0, v0}, 64'd0);
      if (k == 15) begin
        check("acc_valid", {63'd0, v0}, 64'd1);
        check("acc_mask", {60'd0, m0}, 64'd5);
        check("acc_cycle", {32'd0, c0}, {32'd0, start[31:0]});
      end
    end
    b0 = 4'd0;
    check("acc_mask_held", {60'd0, m0}, 64'd5);
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    $display("report1 mask=%b cycle=%0d", m0, c0);
    check("acc_xfer_valid", {63'd0, v0}, 64'd0);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;

    // ---------------- clear in COUNT restarts the episode ----------------
    b0 = 4'b0010;
    repeat (10) tick();
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    start = exp_cyc;
    repeat (15) tick();
    check("clrcnt_pre_valid", {63'd0, v0}, 64'd0);
    tick();
    b0 = 4'd0;
    check("clrcnt_valid", {63'd0, v0}, 64'd1);
    check("clrcnt_mask", {60'd0, m0}, 64'd2);
    check("clrcnt_cycle", {32'd0, c0}, {32'd0, start[31:0]});

    // ---------------- reset during REPORT with ready low ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", {63'd0, v0}, 64'd0);
    check("midrst_deadlock", {63'd0, d0}, 64'd0);
    check("midrst_mask", {60'd0, m0}, 64'd0);
    check("midrst_cycle", {32'd0, c0}, 64'd0);
    tick();
    check("midrst_discarded", {63'd0, v0}, 64'd0);

    // ---------------- 4-bit timestamp wrap (THRESH=4) ----------------
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_cyc[3:0] == 4'd15) found = 1'b1;
      else tick();
    end
    check("wrap_found", {63'd0, found}, 64'd1);
    b1 = 4'b0001;
    repeat (3) tick();
    check("wrap_pre_valid", {63'd0, v1}, 64'd0);
    tick();
    b1 = 4'd0;
    check("wrap_valid", {63'd0, v1}, 64'd1);
    check("wrap_cycle15", {60'd0, c1}, 64'd15);
    check("wrap_mask", {60'd0, m1}, 64'd1);
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    $display("report2 mask=%b cycle=%0d", m1, c1);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    start = exp_cyc;
    b1 = 4'b0010;
    repeat (4) tick();
    b1 = 4'd0;
    check("wrap2_valid", {63'd0, v1}, 64'd1);
    check("wrap2_cycle", {60'd0, c1}, {60'd0, start[3:0]});
    check("wrap2_mask", {60'd0, m1}, 64'd2);

    // ---------------- THRESH=1 single-edge episode ----------------
    check("t1_pre_valid", {63'd0, v2}, 64'd0);
    start = exp_cyc;
    b2 = 4'b1000;
    tick();
    b2 = 4'd0;
    check("t1_valid", {63'd0, v2}, 64'd1);
    check("t1_deadlock", {63'd0, d2}, 64'd1);
    check("t1_mask", {60'd0, m2}, 64'd8);
    check("t1_cycle", {56'd0, c2}, {56'd0, start[7:0]});
    rdy2 = 1'b1;
    tick();
    rdy2 = 1'b0;
    $display("report3 mask=%b cycle=%0d", m2, c2);
    check("t1_xfer_valid", {63'd0, v2}, 64'd0);
    check("t1_xfer_deadlock", {63'd0, d2}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
